pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 32, width of alu_result and op2 fields.
- ADDR_W, 32, width of pc field.
- IR_W, 32, width of ir field.
- CTRL_W, 22, width of control-bus field.
REQ-002 SHALL have ports, one per line (clock and reset first):
- clk  in  1  stage clock; one clock; all state updates on falling edge of clk.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry.
- in_pc / in_alu / in_op2 / in_ir / in_ctrl  in  ADDR_W/DATA_W/DATA_W/IR_W/CTRL_W  upstream payload.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream accepts.
- out_pc / out_alu / out_op2 / out_ir / out_ctrl  out  same widths  downstream payload.
- stat_bubbles  out  32  bubble counter (only with PIPE_STAGE_STATS_EN).

Function
REQ-003 Stage SHALL be a 2-entry skid buffer: main register (drives outputs) plus skid register; states EMPTY, ONE, TWO.
REQ-004 Transfer in SHALL occur on a falling edge where in_valid && in_ready; transfer out where out_valid && out_ready.
REQ-005 in_ready SHALL be registered: 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-006 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY; out_* SHALL always show the main register.
REQ-007 Latency SHALL be exactly 1 edge: entry accepted at edge N appears on out_* after edge N when stage was EMPTY, or when in ONE with simultaneous out transfer.
REQ-008 Transitions: EMPTY+in -> ONE; ONE+in+out -> ONE (main loads input); ONE+in only -> TWO (input to skid); ONE+out only -> EMPTY; TWO+out -> ONE (skid moves to main); otherwise hold.
REQ-009 Entry order SHALL be preserved; no entry SHALL be duplicated or dropped absent flush.
REQ-010 Payload registers SHALL hold value unchanged whenever not loaded (stall); out_* stable while out_valid && !out_ready.
REQ-011 flush SHALL, at the edge where it is 1, force EMPTY and discard any same-edge input; flush overrides all transfers.
REQ-012 Payload contents in EMPTY are don't-care but SHALL NOT be X after reset.

Reset
REQ-013 rst SHALL, at the falling edge where sampled 1, force EMPTY, in_ready=1, out_valid=0, all payload and skid registers=0, stat_bubbles=0.
REQ-014 rst SHALL take priority over flush and all transfers; reset mid-transfer discards both entries.

Configuration
REQ-015 Macro PIPE_STAGE_STATS_EN defined: stat_bubbles SHALL increment (wrapping at 2^32-1 -> 0) on each edge where out_ready=1 and out_valid=0, not rst.
REQ-016 Macro PIPE_STAGE_STATS_EN undefined: stat_bubbles port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-017 Shared package SHALL hold default width constants (32/32/32/22) and the state encoding typedef (EMPTY, ONE, TWO).
REQ-018 One sub-module SHALL be natural: pipe_payload_reg, a parametrised enable-load register holding the concatenated payload, instantiated twice (main, skid).

Verification
REQ-019 Bench SHALL cover:
- Reset: rst=1 one edge -> out_valid=0, in_ready=1, out_alu=0.
- Streaming: in_valid=1, out_ready=1, in_alu=1,2,3 on consecutive edges -> out_alu=1,2,3 one edge later each, in_ready stays 1.
- Backpressure: out_ready=0, push alu=0xA,0xB -> TWO, in_ready=0, out_alu=0xA held; raise out_ready -> 0xA then 0xB out, in_ready returns 1.
- Flush: TWO state plus in_valid=1 with flush=1 -> next edge out_valid=0, in_ready=1, pushed entry never appears.
- Simultaneous in/out in ONE: main=0x5, push 0x6 with out_ready=1 -> out_alu=0x6, state ONE.
- Stats (PIPE_STAGE_STATS_EN): out_ready=1, no input for 7 edges -> stat_bubbles=7; preload 0xFFFFFFFF + 1 bubble -> 0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_pkg
// Purpose  : Shared width defaults and state encoding for the pipeline
//            stage register and its payload sub-register.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

  localparam int unsigned C_DEF_DATA_W = 32;
  localparam int unsigned C_DEF_ADDR_W = 32;
  localparam int unsigned C_DEF_IR_W   = 32;
  localparam int unsigned C_DEF_CTRL_W = 22;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_payload_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_payload_reg
// Purpose  : Enable-load register holding one concatenated stage payload.
//            Clears on reset, otherwise holds its value unless load is set.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_payload_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  // Payload storage: cleared by reset, loaded only when enabled.
  always_ff @(negedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule : pipe_payload_reg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Two-entry skid-buffer pipeline stage (main + skid register),
//            state updates on the falling clock edge, registered in_ready.
//            Optional bubble counter enabled by macro PIPE_STAGE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = C_DEF_DATA_W,
  parameter int unsigned ADDR_W = C_DEF_ADDR_W,
  parameter int unsigned IR_W   = C_DEF_IR_W,
  parameter int unsigned CTRL_W = C_DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [IR_W-1:0]   in_ir,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_op2,
  output logic [IR_W-1:0]   out_ir,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stat_bubbles
`endif
);

  localparam int unsigned C_PAYLOAD_W = ADDR_W + 2 * DATA_W + IR_W + CTRL_W;

  stage_state_e           state_q, state_d;
  logic                   in_ready_q;
  logic                   main_load, skid_load, main_from_skid;
  logic                   push, pop;
  logic [C_PAYLOAD_W-1:0] in_payload, main_d, main_q, skid_q;

  assign push       = in_valid && in_ready_q;
  assign pop        = out_valid && out_ready;
  assign in_payload = {in_pc, in_alu, in_op2, in_ir, in_ctrl};
  assign main_d     = main_from_skid ? skid_q : in_payload;

  // Next-state and register-load decode; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and registered ready; ready is computed from next state so it
  // never depends combinationally on out_ready.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  pipe_payload_reg #(.WIDTH(C_PAYLOAD_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load_i (main_load),
    .data_i (main_d),
    .data_o (main_q)
  );

  pipe_payload_reg #(.WIDTH(C_PAYLOAD_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .data_i (in_payload),
    .data_o (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign {out_pc, out_alu, out_op2, out_ir, out_ctrl} = main_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stat_q;

  // Count edges where downstream was ready but nothing was offered.
  always_ff @(negedge clk) begin
    if (rst) begin
      stat_q <= 32'd0;
    end else if (out_ready && !out_valid) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_bubbles = stat_q;
`endif

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg: directed scenarios plus
//            randomized traffic against a queue-based occupancy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int PW = 32 + 32 + 32 + 32 + 22;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_pc, in_alu, in_op2, in_ir;
  logic [21:0] in_ctrl;
  logic [31:0] out_pc, out_alu, out_op2, out_ir;
  logic [21:0] out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stat_bubbles;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO of accepted entries (front = visible entry).
  logic [PW-1:0] mq[$];
  logic [31:0]   m_bub = 32'd0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_alu    (in_alu),
    .in_op2    (in_op2),
    .in_ir     (in_ir),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_alu   (out_alu),
    .out_op2   (out_op2),
    .out_ir    (out_ir),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stat_bubbles (stat_bubbles)
`endif
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs across one falling edge, update the model,
  // then compare outputs on the following rising edge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] alu, input logic ordy);
    logic [31:0] rc;
    bit          do_push, do_pop;
    rst       = r;
    flush     = f;
    in_valid  = iv;
    out_ready = ordy;
    in_alu    = alu;
    in_pc     = $urandom;
    in_op2    = $urandom;
    in_ir     = $urandom;
    rc        = $urandom;
    in_ctrl   = rc[21:0];
    @(negedge clk);
    if (r) begin
      mq.delete();
      m_bub = 32'd0;
    end else begin
      if (ordy && mq.size() == 0) m_bub = m_bub + 32'd1;
      if (f) begin
        mq.delete();
      end else begin
        do_push = iv && (mq.size() < 2);
        do_pop  = ordy && (mq.size() > 0);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({in_pc, in_alu, in_op2, in_ir, in_ctrl});
      end
    end
    @(posedge clk);
    chk("out_valid", PW'(out_valid), PW'(mq.size() != 0));
    chk("in_ready", PW'(in_ready), PW'(mq.size() < 2));
    if (mq.size() != 0)
      chk("payload", {out_pc, out_alu, out_op2, out_ir, out_ctrl}, mq[0]);
`ifdef PIPE_STAGE_STATS_EN
    chk("stat_bubbles", PW'(stat_bubbles), PW'(m_bub));
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_alu = '0; in_op2 = '0; in_ir = '0; in_ctrl = '0;

    // Reset
    step(1, 0, 0, 32'h0, 0);
    chk("rst_out_alu", PW'(out_alu), PW'(32'h0));
    chk("rst_out_valid", PW'(out_valid), PW'(1'b0));
    chk("rst_in_ready", PW'(in_ready), PW'(1'b1));

    // Streaming
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, 32'(i), 1);
      chk("stream_alu", PW'(out_alu), PW'(i));
      chk("stream_rdy", PW'(in_ready), PW'(1'b1));
    end
    step(0, 0, 0, 32'h0, 1);
    chk("stream_drain", PW'(out_valid), PW'(1'b0));

    // Backpressure
    step(0, 0, 1, 32'hA, 0);
    step(0, 0, 1, 32'hB, 0);
    chk("bp_rdy_low", PW'(in_ready), PW'(1'b0));
    chk("bp_hold_a", PW'(out_alu), PW'(32'hA));
    step(0, 0, 1, 32'hC, 0);
    chk("bp_stall_a", PW'(out_alu), PW'(32'hA));
    step(0, 0, 0, 32'h0, 1);
    chk("bp_out_b", PW'(out_alu), PW'(32'hB));
    chk("bp_rdy_back", PW'(in_ready), PW'(1'b1));
    step(0, 0, 0, 32'h0, 1);
    chk("bp_empty", PW'(out_valid), PW'(1'b0));

    // Flush while full with an incoming entry
    step(0, 0, 1, 32'hC, 0);
    step(0, 0, 1, 32'hD, 0);
    step(0, 1, 1, 32'hE, 0);
    chk("fl_valid", PW'(out_valid), PW'(1'b0));
    chk("fl_rdy", PW'(in_ready), PW'(1'b1));
    step(0, 0, 0, 32'h0, 1);
    chk("fl_no_e", PW'(out_valid), PW'(1'b0));

    // Simultaneous in/out while holding one entry
    step(0, 0, 1, 32'h5, 0);
    step(0, 0, 1, 32'h6, 1);
    chk("sim_alu", PW'(out_alu), PW'(32'h6));
    chk("sim_one_v", PW'(out_valid), PW'(1'b1));
    chk("sim_one_r", PW'(in_ready), PW'(1'b1));
    step(0, 0, 0, 32'h0, 1);

`ifdef PIPE_STAGE_STATS_EN
    step(1, 0, 0, 32'h0, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 32'h0, 1);
    chk("bub7", PW'(stat_bubbles), PW'(32'd7));
    force dut.stat_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_q;
    m_bub = 32'hFFFF_FFFF;
    step(0, 0, 0, 32'h0, 1);
    chk("bub_wrap", PW'(stat_bubbles), PW'(32'd0));
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire
